// File: rtl/mem_wb_pipe_if.sv
// MEM/WB pipeline bundle: MEM-stage inputs, forwarding lookup, write-back results.
// master = MEM-stage / hazard side, slave = the pipeline register itself.
interface mem_wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [1:0]        wb_ctrl;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] fwd_addr;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [31:0]       retired;

    modport master (
        output stall, flush, in_valid, wb_ctrl, mem_dout, alu_res, rd_addr, fwd_addr,
        input  wb_we, wb_addr, wb_data, out_valid, fwd_hit, fwd_data, retired
    );

    modport slave (
        input  stall, flush, in_valid, wb_ctrl, mem_dout, alu_res, rd_addr, fwd_addr,
        output wb_we, wb_addr, wb_data, out_valid, fwd_hit, fwd_data, retired
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: DEPTH stages, write-back resolve, forwarding lookup, retire count.
// Latency DEPTH edges; stall holds everything, flush clears stages (flush wins over stall).
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_wb_pipe_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        ctrl;
        logic [DATA_W-1:0] mdout;
        logic [DATA_W-1:0] alu;
        logic [ADDR_W-1:0] rd;
    } stage_t;

    stage_t      stg_q [DEPTH];
    stage_t      stg_d [DEPTH];
    logic [31:0] ret_q;
    logic [31:0] ret_d;
    stage_t      fin;
    logic              fwd_hit_c;
    logic [DATA_W-1:0] fwd_data_c;

    function automatic logic [DATA_W-1:0] resolve(input stage_t s);
        return s.ctrl[0] ? s.mdout : s.alu;
    endfunction

    // Register 0 is hardwired, so a write to it is never a real write.
    function automatic logic writes(input stage_t s);
        return s.valid & s.ctrl[1] & (s.rd != '0);
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stg_d[k] = stg_q[k];
        end
        ret_d = ret_q;
        if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_d[k] = '0;
            end
        end else if (!bus.stall) begin
            stg_d[0].valid = bus.in_valid;
            stg_d[0].ctrl  = bus.wb_ctrl;
            stg_d[0].mdout = bus.mem_dout;
            stg_d[0].alu   = bus.alu_res;
            stg_d[0].rd    = bus.rd_addr;
            for (int k = 1; k < DEPTH; k++) begin
                stg_d[k] = stg_q[k-1];
            end
            if (stg_q[DEPTH-1].valid) begin
                ret_d = ret_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_q[k] <= '0;
            end
            ret_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_q[k] <= stg_d[k];
            end
            ret_q <= ret_d;
        end
    end

    assign fin = stg_q[DEPTH-1];

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (writes(stg_q[k]) && (stg_q[k].rd == bus.fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = resolve(stg_q[k]);
            end
        end
    end

    assign bus.wb_we     = writes(fin);
    assign bus.wb_addr   = fin.rd;
    assign bus.wb_data   = resolve(fin);
    assign bus.out_valid = fin.valid;
    assign bus.fwd_hit   = fwd_hit_c;
    assign bus.fwd_data  = fwd_data_c;
    assign bus.retired   = ret_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe at DEPTH=3: instruction-level model compared every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_mem_wb_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_wb_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_wb_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        v;
        bit [1:0]  c;
        bit [31:0] md;
        bit [31:0] alu;
        bit [4:0]  rd;
    } ins_t;

    ins_t      m [D];
    bit [31:0] m_ret;

    function automatic bit m_writes(input ins_t i);
        return i.v && i.c[1] && (i.rd != 5'd0);
    endfunction

    function automatic bit [31:0] m_val(input ins_t i);
        return i.c[0] ? i.md : i.alu;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: a row of in-flight instructions, youngest at index 0.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < D; k++) m[k] = '{default: 0};
            m_ret = 0;
        end else if (bus.flush) begin
            for (int k = 0; k < D; k++) m[k] = '{default: 0};
        end else if (!bus.stall) begin
            if (m[D-1].v) m_ret = m_ret + 1;
            for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
            m[0] = '{bus.in_valid, bus.wb_ctrl, bus.mem_dout, bus.alu_res, bus.rd_addr};
        end
    end

    always @(negedge clk) begin
        ins_t      f;
        bit        eh;
        bit [31:0] ed;
        if (reset) begin
            f  = m[D-1];
            eh = 1'b0;
            ed = 32'd0;
            for (int k = 0; k < D; k++) begin
                if (!eh && m_writes(m[k]) && m[k].rd == bus.fwd_addr) begin
                    eh = 1'b1;
                    ed = m_val(m[k]);
                end
            end
            chk("cyc_wb_we",     32'(bus.wb_we),     32'(m_writes(f)));
            chk("cyc_wb_addr",   32'(bus.wb_addr),   32'(f.rd));
            chk("cyc_wb_data",   bus.wb_data,        m_val(f));
            chk("cyc_out_valid", 32'(bus.out_valid), 32'(f.v));
            chk("cyc_fwd_hit",   32'(bus.fwd_hit),   32'(eh));
            chk("cyc_fwd_data",  bus.fwd_data,       ed);
            chk("cyc_retired",   bus.retired,        m_ret);
        end
    end

    task automatic push(input bit v, input bit [1:0] c, input bit [31:0] md,
                        input bit [31:0] alu, input bit [4:0] rd);
        bus.in_valid = v;
        bus.wb_ctrl  = c;
        bus.mem_dout = md;
        bus.alu_res  = alu;
        bus.rd_addr  = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic flush_pipe();
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b1;
        bus.wb_ctrl  = 2'b11;
        bus.mem_dout = 32'hAAAA_5555;
        bus.alu_res  = 32'h1357_9BDF;
        bus.rd_addr  = 5'd5;
        bus.fwd_addr = 5'd5;
        #2;
        chk("rst_wb_we",     32'(bus.wb_we),     32'd0);
        chk("rst_wb_addr",   32'(bus.wb_addr),   32'd0);
        chk("rst_wb_data",   bus.wb_data,        32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fwd_hit",   32'(bus.fwd_hit),   32'd0);
        chk("rst_fwd_data",  bus.fwd_data,       32'd0);
        chk("rst_retired",   bus.retired,        32'd0);
        bus.in_valid = 1'b0;
        bus.fwd_addr = 5'd0;
        #1 reset = 1'b1;

        // First instruction after reset
        push(1, 2'b10, 32'd0, 32'h1234, 5'd5);
        idle();
        idle();
        chk("first_we",   32'(bus.wb_we),   32'd1);
        chk("first_addr", 32'(bus.wb_addr), 32'd5);
        chk("first_data", bus.wb_data,      32'h1234);
        chk("first_ret0", bus.retired,      32'd0);
        idle();
        chk("first_ret1", bus.retired,      32'd1);

        // MemtoReg select and register-0 suppression
        push(1, 2'b11, 32'hDEAD_BEEF, 32'h10, 5'd9);
        push(1, 2'b10, 32'hDEAD_BEEF, 32'h10, 5'd9);
        push(1, 2'b10, 32'hDEAD_BEEF, 32'h10, 5'd0);
        chk("m2r_mem", bus.wb_data, 32'hDEAD_BEEF);
        idle();
        chk("m2r_alu", bus.wb_data, 32'h10);
        idle();
        chk("rd0_we",    32'(bus.wb_we),     32'd0);
        chk("rd0_valid", 32'(bus.out_valid), 32'd1);
        idle();
        chk("m2r_ret", bus.retired, 32'd4);

        // Stall mid-stream, with a valid input offered while stalled
        push(1, 2'b10, 32'd0, 32'hA1, 5'd1);
        push(1, 2'b10, 32'd0, 32'hB2, 5'd2);
        push(1, 2'b10, 32'd0, 32'hC3, 5'd3);
        chk("stall_a", bus.wb_data, 32'hA1);
        bus.stall = 1'b1;
        push(1, 2'b10, 32'd0, 32'hBAD, 5'd9);
        push(1, 2'b10, 32'd0, 32'hBAD, 5'd9);
        chk("stall_hold", bus.wb_data, 32'hA1);
        chk("stall_ret",  bus.retired, 32'd4);
        bus.stall = 1'b0;
        idle();
        chk("stall_b", bus.wb_data, 32'hB2);
        idle();
        chk("stall_c", bus.wb_data, 32'hC3);
        idle();
        chk("stall_ret3", bus.retired,      32'd7);
        chk("stall_empty", 32'(bus.out_valid), 32'd0);

        // Flush together with stall discards everything incl. the presented input
        push(1, 2'b10, 32'd0, 32'hD0, 5'd10);
        push(1, 2'b10, 32'd0, 32'hE0, 5'd11);
        push(1, 2'b10, 32'd0, 32'hF0, 5'd12);
        bus.fwd_addr = 5'd10;
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        push(1, 2'b10, 32'd0, 32'h77, 5'd13);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_hit",   32'(bus.fwd_hit),   32'd0);
        chk("flush_ret",   bus.retired,        32'd7);
        idle();
        idle();
        idle();
        chk("flush_drop", 32'(bus.out_valid), 32'd0);
        chk("flush_ret2", bus.retired,        32'd7);

        // Forwarding priority
        push(1, 2'b10, 32'd0, 32'h1, 5'd7);
        push(1, 2'b11, 32'hCAFE, 32'h5, 5'd3);
        push(1, 2'b10, 32'd0, 32'h2, 5'd7);
        bus.fwd_addr = 5'd7;
        #1;
        chk("fwd_young_hit",  32'(bus.fwd_hit), 32'd1);
        chk("fwd_young_data", bus.fwd_data,     32'h2);
        bus.fwd_addr = 5'd3;
        #1;
        chk("fwd_m2r_data", bus.fwd_data, 32'hCAFE);
        bus.fwd_addr = 5'd0;
        #1;
        chk("fwd_r0_hit",  32'(bus.fwd_hit), 32'd0);
        chk("fwd_r0_data", bus.fwd_data,     32'd0);
        flush_pipe();
        push(1, 2'b10, 32'd0, 32'h1, 5'd7);
        push(1, 2'b11, 32'hCAFE, 32'h5, 5'd3);
        push(0, 2'b10, 32'd0, 32'h2, 5'd7);
        bus.fwd_addr = 5'd7;
        #1;
        chk("fwd_old_hit",  32'(bus.fwd_hit), 32'd1);
        chk("fwd_old_data", bus.fwd_data,     32'h1);
        flush_pipe();
        bus.fwd_addr = 5'd0;

        // Retired counter wrap
        push(1, 2'b10, 32'd0, 32'h44, 5'd4);
        idle();
        idle();
        force dut.ret_q = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        #1 release dut.ret_q;
        chk("wrap_pre", bus.retired, 32'hFFFF_FFFF);
        idle();
        chk("wrap_zero", bus.retired, 32'd0);

        // Asynchronous reset with a full pipe
        push(1, 2'b10, 32'd0, 32'h11, 5'd1);
        push(1, 2'b10, 32'd0, 32'h22, 5'd2);
        push(1, 2'b10, 32'd0, 32'h33, 5'd3);
        bus.fwd_addr = 5'd2;
        idle();
        chk("arst_pre_ret",  bus.retired,     32'd1);
        chk("arst_pre_data", bus.wb_data,     32'h22);
        #1 reset = 1'b0;
        #1;
        chk("arst_we",    32'(bus.wb_we),     32'd0);
        chk("arst_addr",  32'(bus.wb_addr),   32'd0);
        chk("arst_data",  bus.wb_data,        32'd0);
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_hit",   32'(bus.fwd_hit),   32'd0);
        chk("arst_ret",   bus.retired,        32'd0);
        reset = 1'b1;
        push(1, 2'b11, 32'h66, 32'd0, 5'd6);
        idle();
        idle();
        chk("post_we",   32'(bus.wb_we),   32'd1);
        chk("post_addr", 32'(bus.wb_addr), 32'd6);
        chk("post_data", bus.wb_data,      32'h66);
        idle();
        chk("post_ret", bus.retired, 32'd1);

        #10;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register for the CPU core, placed between the memory-access stage and the register-file write port. It carries write-back control, memory read data, ALU result and destination address through DEPTH register stages, with stall, flush and per-stage valid tracking. It also resolves the final write-back value and write enable, provides a priority forwarding lookup over all in-flight stages, and keeps a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 32, width of memory data, ALU result and write-back data
- ADDR_W, 5, register address width
- DEPTH, 1, number of register stages (legal 1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- stall  in  1  hold all stages unchanged
- flush  in  1  synchronously clear all stages
- in_valid  in  1  MEM stage holds a real instruction
- wb_ctrl  in  2  bit1 = RegWrite, bit0 = MemtoReg
- mem_dout  in  DATA_W  data memory read data
- alu_res  in  DATA_W  ALU result
- rd_addr  in  ADDR_W  destination register
- fwd_addr  in  ADDR_W  source register to look up for forwarding
- wb_we  out  1  register-file write enable
- wb_addr  out  ADDR_W  register-file write address
- wb_data  out  DATA_W  register-file write data
- out_valid  out  1  final stage valid
- fwd_hit  out  1  fwd_addr matches a pending write
- fwd_data  out  DATA_W  forwarded value
- retired  out  32  count of instructions leaving the final stage

## Operation
- Stage k (0..DEPTH-1) holds {valid, ctrl, mdout, alu, rd}. Stage 0 captures inputs; stage k captures stage k-1; final stage = DEPTH-1.
- Reset (reset=0, asynchronous): every stage field = 0, retired = 0. Outputs therefore: wb_we=0, wb_addr=0, wb_data=0, out_valid=0, fwd_hit=0, fwd_data=0.
- Per clock, priority: flush > stall > advance.
  - flush=1: all stage fields cleared to 0 (identical to reset, but synchronous); retired unchanged.
  - stall=1, flush=0: all stages and retired hold.
  - otherwise: pipeline shifts one stage; stage 0 loads {in_valid, wb_ctrl, mem_dout, alu_res, rd_addr}.
- Write-back (combinational from final stage):
  - wb_data = ctrl[0] ? mdout : alu.
  - wb_we = valid & ctrl[1] & (rd != 0). Register 0 is never written.
  - wb_addr = rd.
- wb_we is not gated by stall; a held final stage keeps asserting the same write (idempotent).
- Forwarding (combinational): candidate stage k hits when valid & ctrl[1] & rd != 0 & rd == fwd_addr. Youngest hit (lowest k) wins; fwd_data = that stage's resolved value (MemtoReg mux applied). No hit: fwd_hit=0, fwd_data=0. fwd_addr=0 never hits.
- retired increments by 1 on a clock edge where final-stage valid=1, stall=0, flush=0; 32-bit wrap 0xFFFFFFFF -> 0.

## Timing
- Latency: input sampled at edge N appears on wb_* after edge N+DEPTH-1 (i.e. visible in cycle following DEPTH advancing edges), provided no stall.
- Each stall cycle adds exactly one cycle of latency to every in-flight instruction; no data lost or duplicated.
- Flush discards all in-flight instructions, including the one presented on the same edge.
- reset deassertion: first advancing edge after reset returns to 1 loads stage 0 normally.
- Reset asserted mid-stream clears immediately (no clock needed); retired returns to 0.
- DEPTH=1 behaves as a single stage register with the added control; forwarding looks at that one stage.

## Test plan
- Reset: drive reset=0 with nonzero inputs, no clock edge -> all outputs 0; release, push in_valid=1, wb_ctrl=2'b10, alu_res=0x1234, rd_addr=5 -> after DEPTH edges wb_we=1, wb_addr=5, wb_data=0x1234, retired increments once it retires.
- MemtoReg select: wb_ctrl=2'b11, mem_dout=0xDEADBEEF, alu_res=0x10 -> wb_data=0xDEADBEEF; wb_ctrl=2'b10 -> 0x10; rd_addr=0 with RegWrite -> wb_we=0.
- Stall/flush: DEPTH=3, stream A,B,C, stall 2 cycles mid-stream -> outputs frozen, order A,B,C preserved, retired=3; assert stall and flush together -> all stages cleared, out_valid=0, retired unchanged.
- Forwarding priority: DEPTH=3, stage0 rd=7 alu=0x2, stage2 rd=7 alu=0x1, fwd_addr=7 -> fwd_hit=1, fwd_data=0x2; invalidate stage0 -> 0x1; fwd_addr=0 -> fwd_hit=0.
- Counter wrap: force retired to 0xFFFFFFFF via stream of valid retirements (or preloaded bench) -> next retirement gives 0.
- Async reset mid-operation: full pipe, pulse reset low between edges -> outputs 0 immediately, retired=0, subsequent stream behaves as after power-up.
